// File: rtl/bp_pkg.sv
// Shared definitions for the branch-prediction resolve queue.
//   BP_DBITS   : default PC width that bp_entry_t is built for
//   INSTSIZE   : byte stride of sequential instructions (for prediction streams)
//   bp_entry_t : one queue entry, {pc, pred_pc}, at the default PC width
//   bp_state_t : resolve-queue FSM state
package bp_pkg;

    localparam int BP_DBITS = 32;
    localparam int INSTSIZE = 4;

    typedef struct packed {
        logic [BP_DBITS-1:0] pc;
        logic [BP_DBITS-1:0] pred_pc;
    } bp_entry_t;

    typedef enum logic {
        RUN = 1'b0,   // normal push / resolve
        RDR = 1'b1    // single redirect cycle
    } bp_state_t;

endpackage

// File: rtl/bp_fifo.sv
// Synchronous circular FIFO with a synchronous clear.
//   clk, reset  : clock, asynchronous active-low reset
//   clear       : empties the FIFO at the next edge (wins over push/pop)
//   push, wdata : write wdata at tail (ignored when full)
//   pop         : advance head (ignored when empty)
//   rdata       : entry at head (meaningless when empty)
//   full, empty : status flags
//   count       : number of valid entries, registered
module bp_fifo
    import bp_pkg::*;
#(
    parameter int W     = 64,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       push,
    input  logic [W-1:0]               wdata,
    input  logic                       pop,
    output logic [W-1:0]               rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[head];

    // Pointers are exactly PW bits wide, so wrap modulo DEPTH is free.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (clear) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (do_push) tail <= tail + 1'b1;
            if (do_pop)  head <= head + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: count gates every read that matters.
    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[tail] <= wdata;
    end

endmodule

// File: rtl/bp_resolve_queue.sv
// In-order queue of fetch-time predictions checked against execution outcomes.
//   clk, reset        : clock, asynchronous active-low reset
//   push_*            : fetch pushes {pc, pred_pc}; push_ready is combinational
//   res_*             : AGEX resolves the oldest entry with the real next PC
//   redirect_valid/pc : one-cycle redirect/flush pulse and restart address
//   occupancy         : valid entries
//   res_error         : sticky flag for empty resolves and PC mismatches
//   br_count          : saturating count of popped control-flow resolves
//   mispredict_count  : saturating count of mispredicts
// Handshake: a push transfers on a cycle where push_valid && push_ready; a
// resolve is consumed on any RUN cycle with res_valid (there is no ready),
// popping the head when the queue is non-empty.
module bp_resolve_queue
    import bp_pkg::*;
#(
    parameter int DBITS = 32,
    parameter int DEPTH = 8,
    parameter int CNTW  = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_valid,
    input  logic [DBITS-1:0]         push_pc,
    input  logic [DBITS-1:0]         push_pred_pc,
    output logic                     push_ready,
    input  logic                     res_valid,
    input  logic [DBITS-1:0]         res_pc,
    input  logic                     res_is_branch,
    input  logic [DBITS-1:0]         res_next_pc,
    output logic                     redirect_valid,
    output logic [DBITS-1:0]         redirect_pc,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic                     res_error,
    output logic [CNTW-1:0]          br_count,
    output logic [CNTW-1:0]          mispredict_count
);

    // Same layout as bp_entry_t, sized by DBITS.
    typedef struct packed {
        logic [DBITS-1:0] pc;
        logic [DBITS-1:0] pred_pc;
    } entry_t;

    bp_state_t state;
    bp_state_t state_next;
    entry_t    head_entry;
    entry_t    push_entry;
    logic      fifo_full;
    logic      fifo_empty;
    logic      res_take;
    logic      mispredict;
    logic      proto_err;
    logic      fifo_push;
    logic      fifo_pop;

    assign push_entry = '{pc: push_pc, pred_pc: push_pred_pc};

    // Deliberately independent of res_valid: a full queue never takes a push.
    assign push_ready = (state == RUN) && !fifo_full;

    always_comb begin
        state_next = state;
        res_take   = 1'b0;
        mispredict = 1'b0;
        proto_err  = 1'b0;
        fifo_push  = 1'b0;
        fifo_pop   = 1'b0;
        case (state)
            RUN: begin
                res_take   = res_valid && !fifo_empty;
                mispredict = res_take && (head_entry.pred_pc != res_next_pc);
                proto_err  = res_valid && (fifo_empty || head_entry.pc != res_pc);
                // A mispredict flushes everything, including a same-cycle push.
                fifo_push  = push_valid && push_ready && !mispredict;
                fifo_pop   = res_take && !mispredict;
                if (mispredict) state_next = RDR;
            end
            RDR: begin
                state_next = RUN;
            end
            default: state_next = RUN;
        endcase
    end

    bp_fifo #(
        .W     ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clear (mispredict),
        .push  (fifo_push),
        .wdata (push_entry),
        .pop   (fifo_pop),
        .rdata (head_entry),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (occupancy)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= RUN;
            redirect_valid   <= 1'b0;
            redirect_pc      <= '0;
            res_error        <= 1'b0;
            br_count         <= '0;
            mispredict_count <= '0;
        end else begin
            state          <= state_next;
            redirect_valid <= mispredict;
            if (mispredict) redirect_pc <= res_next_pc;
            if (proto_err)  res_error   <= 1'b1;
            if (res_take && res_is_branch && br_count != '1)
                br_count <= br_count + 1'b1;
            if (mispredict && mispredict_count != '1)
                mispredict_count <= mispredict_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_bp_resolve_queue.sv
module tb_bp_resolve_queue;
    import bp_pkg::*;

    localparam int DBITS = 32;
    localparam int DEPTH = 8;
    localparam int CNTW  = 32;

    logic             clk;
    logic             reset;
    logic             push_valid;
    logic [DBITS-1:0] push_pc;
    logic [DBITS-1:0] push_pred_pc;
    logic             push_ready;
    logic             res_valid;
    logic [DBITS-1:0] res_pc;
    logic             res_is_branch;
    logic [DBITS-1:0] res_next_pc;
    logic             redirect_valid;
    logic [DBITS-1:0] redirect_pc;
    logic [$clog2(DEPTH):0] occupancy;
    logic             res_error;
    logic [CNTW-1:0]  br_count;
    logic [CNTW-1:0]  mispredict_count;

    bp_resolve_queue #(.DBITS(DBITS), .DEPTH(DEPTH), .CNTW(CNTW)) dut (
        .clk              (clk),
        .reset            (reset),
        .push_valid       (push_valid),
        .push_pc          (push_pc),
        .push_pred_pc     (push_pred_pc),
        .push_ready       (push_ready),
        .res_valid        (res_valid),
        .res_pc           (res_pc),
        .res_is_branch    (res_is_branch),
        .res_next_pc      (res_next_pc),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .occupancy        (occupancy),
        .res_error        (res_error),
        .br_count         (br_count),
        .mispredict_count (mispredict_count)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;

    // ---------------- scoreboard state ----------------
    logic [DBITS-1:0] exp_q[$];     // expected redirect_pc values
    bp_entry_t        mq[$];        // model queue contents
    logic             m_rdr;
    logic             m_err;
    int               m_br;
    int               m_mis;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic pv, input logic [31:0] ppc, input logic [31:0] ppred,
                         input logic rv, input logic [31:0] rpc, input logic rbr,
                         input logic [31:0] rnext);
        push_valid    = pv;
        push_pc       = ppc;
        push_pred_pc  = ppred;
        res_valid     = rv;
        res_pc        = rpc;
        res_is_branch = rbr;
        res_next_pc   = rnext;
    endtask

    task automatic apply(input logic pv, input logic [31:0] ppc, input logic [31:0] ppred,
                         input logic rv, input logic [31:0] rpc, input logic rbr,
                         input logic [31:0] rnext);
        @(negedge clk);
        drive(pv, ppc, ppred, rv, rpc, rbr, rnext);
        @(posedge clk);
        #1;
        n_vec++;
    endtask

    task automatic idle();
        apply(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_ready"}, push_ready, 1);
        chk({tag, "_rdr"},   redirect_valid, 0);
        chk({tag, "_rpc"},   redirect_pc, 0);
        chk({tag, "_occ"},   occupancy, 0);
        chk({tag, "_err"},   res_error, 0);
        chk({tag, "_br"},    br_count, 0);
        chk({tag, "_mis"},   mispredict_count, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_reset_vals("reset");
        mq.delete();
        exp_q.delete();
        m_rdr = 0; m_err = 0; m_br = 0; m_mis = 0;
    endtask

    // One scoreboarded cycle: resolves use the model head so a correct DUT
    // never mispredicts unless 'wrong' is set.
    task automatic sb_step(input logic pv, input logic rv, input logic rbr, input logic wrong);
        logic [31:0] ppc, ppred, rpc, rnext;
        logic        ready, take, mis;
        ppc   = 32'($urandom_range(0, 16'hffff)) << 2;
        ppred = ($urandom_range(0, 3) == 0) ? (32'($urandom_range(0, 16'hffff)) << 2)
                                            : ppc + INSTSIZE;
        rpc   = (mq.size() > 0) ? mq[0].pc : 32'h0;
        rnext = (mq.size() > 0) ? mq[0].pred_pc : 32'h0;
        if (wrong) rnext = rnext + 32'h40;
        ready = !m_rdr && (mq.size() < DEPTH);
        take  = rv && !m_rdr && (mq.size() > 0);
        mis   = take && wrong;
        if (rv && !m_rdr && mq.size() == 0) m_err = 1;
        if (take && rbr) m_br++;
        if (mis) begin
            m_mis++;
            exp_q.push_back(rnext);
            mq.delete();
        end else begin
            if (take) void'(mq.pop_front());
            if (pv && ready) mq.push_back('{pc: ppc, pred_pc: ppred});
        end
        m_rdr = mis;
        apply(pv, ppc, ppred, rv, rpc, rbr, rnext);
        chk("sb_occ",   occupancy, mq.size());
        chk("sb_rdr",   redirect_valid, m_rdr);
        chk("sb_ready", push_ready, !m_rdr && (mq.size() < DEPTH));
        chk("sb_br",    br_count, m_br);
        chk("sb_mis",   mispredict_count, m_mis);
        chk("sb_err",   res_error, m_err);
        if (redirect_valid) begin
            if (exp_q.size() == 0) chk("sb_unexpected_redirect", 1, 0);
            else                   chk("sb_redirect_pc", redirect_pc, exp_q.pop_front());
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        pv;
        logic [31:0] ppc;
        logic [31:0] ppred;
        logic        rv;
        logic [31:0] rpc;
        logic        rbr;
        logic [31:0] rnext;
        int          e_occ;
        logic        e_rdr;
        logic [31:0] e_rpc;
        logic        e_ready;
        int          e_br;
        int          e_mis;
        logic        e_err;
    } vec_t;

    vec_t vecs[16];

    initial begin
        // sequential, no branch
        vecs[0]  = '{1, 32'h100, 32'h104, 0, 0,       0, 0,       1, 0, 0,       1, 0, 0, 0};
        vecs[1]  = '{1, 32'h104, 32'h108, 0, 0,       0, 0,       2, 0, 0,       1, 0, 0, 0};
        vecs[2]  = '{1, 32'h108, 32'h10C, 0, 0,       0, 0,       3, 0, 0,       1, 0, 0, 0};
        vecs[3]  = '{0, 0,       0,       1, 32'h100, 0, 32'h104, 2, 0, 0,       1, 0, 0, 0};
        vecs[4]  = '{0, 0,       0,       1, 32'h104, 0, 32'h108, 1, 0, 0,       1, 0, 0, 0};
        vecs[5]  = '{0, 0,       0,       1, 32'h108, 0, 32'h10C, 0, 0, 0,       1, 0, 0, 0};
        // taken-branch mispredict with a same-cycle push that must be dropped
        vecs[6]  = '{1, 32'h200, 32'h204, 0, 0,       0, 0,       1, 0, 0,       1, 0, 0, 0};
        vecs[7]  = '{1, 32'h204, 32'h208, 0, 0,       0, 0,       2, 0, 0,       1, 0, 0, 0};
        vecs[8]  = '{1, 32'h208, 32'h20C, 0, 0,       0, 0,       3, 0, 0,       1, 0, 0, 0};
        vecs[9]  = '{1, 32'h20C, 32'h210, 1, 32'h200, 1, 32'h300, 0, 1, 32'h300, 0, 1, 1, 0};
        // redirect cycle: push and resolve both ignored
        vecs[10] = '{1, 32'h300, 32'h304, 1, 32'h300, 1, 32'h999, 0, 0, 32'h300, 1, 1, 1, 0};
        vecs[11] = '{0, 0,       0,       0, 0,       0, 0,       0, 0, 32'h300, 1, 1, 1, 0};
        // protocol errors: empty resolve, then PC mismatch that still pops
        vecs[12] = '{0, 0,       0,       1, 0,       0, 0,       0, 0, 32'h300, 1, 1, 1, 1};
        vecs[13] = '{1, 32'h400, 32'h404, 0, 0,       0, 0,       1, 0, 32'h300, 1, 1, 1, 1};
        vecs[14] = '{0, 0,       0,       1, 32'h404, 0, 32'h404, 0, 0, 32'h300, 1, 1, 1, 1};
        vecs[15] = '{0, 0,       0,       0, 0,       0, 0,       0, 0, 32'h300, 1, 1, 1, 1};
    end

    // ---------------- test sequence ----------------
    initial begin
        drive(0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        #1;
        chk("async_reset_rdr", redirect_valid, 0);
        repeat (2) @(posedge clk);
        do_reset();

        // table: sequential, mispredict, redirect cycle, protocol errors
        for (int i = 0; i < 16; i++) begin
            apply(vecs[i].pv, vecs[i].ppc, vecs[i].ppred, vecs[i].rv,
                  vecs[i].rpc, vecs[i].rbr, vecs[i].rnext);
            chk($sformatf("v%0d_occ", i),   occupancy, vecs[i].e_occ);
            chk($sformatf("v%0d_rdr", i),   redirect_valid, vecs[i].e_rdr);
            chk($sformatf("v%0d_rpc", i),   redirect_pc, vecs[i].e_rpc);
            chk($sformatf("v%0d_ready", i), push_ready, vecs[i].e_ready);
            chk($sformatf("v%0d_br", i),    br_count, vecs[i].e_br);
            chk($sformatf("v%0d_mis", i),   mispredict_count, vecs[i].e_mis);
            chk($sformatf("v%0d_err", i),   res_error, vecs[i].e_err);
        end

        // full queue: ninth push with simultaneous resolve is rejected
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            apply(1, 32'h1000 + 4*i, 32'h1004 + 4*i, 0, 0, 0, 0);
            chk($sformatf("fill%0d_occ", i), occupancy, i + 1);
        end
        chk("full_ready", push_ready, 0);
        apply(1, 32'h2000, 32'h2004, 1, 32'h1000, 0, 32'h1004);
        chk("full_pushres_occ", occupancy, 7);
        chk("full_pushres_rdr", redirect_valid, 0);
        chk("full_after_ready", push_ready, 1);
        for (int i = 1; i < DEPTH; i++) begin
            apply(0, 0, 0, 1, 32'h1000 + 4*i, 0, 32'h1004 + 4*i);
            chk($sformatf("drain%0d_occ", i), occupancy, DEPTH - 1 - i);
            chk($sformatf("drain%0d_rdr", i), redirect_valid, 0);
        end
        chk("full_drain_err", res_error, 0);

        // pointer wrap with scoreboard, then a scoreboarded mispredict
        do_reset();
        repeat (3) sb_step(1, 0, 0, 0);
        for (int i = 0; i < 20; i++) sb_step(1, 1, 1'($urandom_range(0, 1)), 0);
        repeat (3) sb_step(0, 1, 0, 0);
        repeat (5) sb_step(1, 0, 0, 0);
        sb_step(1, 1, 1, 1);
        sb_step(1, 1, 0, 0);
        sb_step(0, 0, 0, 0);
        chk("sb_exp_q_empty", exp_q.size(), 0);

        // reset during the redirect cycle
        do_reset();
        apply(1, 32'h500, 32'h504, 0, 0, 0, 0);
        apply(1, 32'h504, 32'h508, 0, 0, 0, 0);
        apply(0, 0, 0, 1, 32'h500, 0, 32'h600);
        chk("rdr6_valid", redirect_valid, 1);
        chk("rdr6_pc", redirect_pc, 32'h600);
        #2;
        drive(0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        #1;
        chk("rst_in_rdr_valid", redirect_valid, 0);
        chk("rst_in_rdr_occ", occupancy, 0);
        chk("rst_in_rdr_mis", mispredict_count, 0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            idle();
            check_reset_vals($sformatf("post_rst%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
